// File: rtl/pixel_write_sched.sv
// Frame-buffer write-port scheduler: packs UART R,G,B bytes into pixels at
// consecutive addresses, or hands the port to a constant-colour clear engine.
module pixel_write_sched #(
  parameter int          PIXEL_COUNT    = 196608,
  parameter int          ADDR_W         = $clog2(PIXEL_COUNT),
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [23:0] CLEAR_COLOR    = 24'h000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              clear_req,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              sync_err,
  output logic              byte_drop
);

  localparam int                TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(PIXEL_COUNT - 1);
  localparam logic [TW-1:0]     TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GOT_R, GOT_G, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pix_addr;
  logic [TW-1:0]     tcnt;
  logic [7:0]        r_byte;
  logic [7:0]        g_byte;
  logic              clear_go;
  logic              armed;

  assign clear_go = clear_req && (state != CLEAR);
  // A link is only considered stalled once a pixel or a frame is partially received.
  assign armed    = (state != CLEAR) && ((state != IDLE) || (pix_addr != '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pix_addr   <= '0;
      tcnt       <= '0;
      r_byte     <= '0;
      g_byte     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      byte_drop  <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      byte_drop  <= 1'b0;

      if (state == CLEAR) begin
        byte_drop <= rx_ready;
        // wr_addr doubles as the clear address; leaving after the last one is shown.
        if (wr_addr == LAST_ADDR) begin
          state <= IDLE;
        end else begin
          wr_en   <= 1'b1;
          busy    <= 1'b1;
          wr_addr <= wr_addr + 1'b1;
        end
      end else if (clear_go) begin
        byte_drop <= rx_ready;
        state     <= CLEAR;
        pix_addr  <= '0;
        tcnt      <= '0;
        wr_en     <= 1'b1;
        busy      <= 1'b1;
        wr_addr   <= '0;
        wr_data   <= CLEAR_COLOR;
      end else if (rx_ready) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            r_byte <= rx_data;
            state  <= GOT_R;
          end
          GOT_R: begin
            g_byte <= rx_data;
            state  <= GOT_G;
          end
          default: begin
            state      <= IDLE;
            wr_en      <= 1'b1;
            wr_addr    <= pix_addr;
            wr_data    <= {r_byte, g_byte, rx_data};
            frame_done <= (pix_addr == LAST_ADDR);
            pix_addr   <= (pix_addr == LAST_ADDR) ? '0 : pix_addr + 1'b1;
          end
        endcase
      end else if (armed) begin
        if (tcnt == TIMEOUT_LAST) begin
          sync_err <= 1'b1;
          state    <= IDLE;
          pix_addr <= '0;
          tcnt     <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_write_sched.sv
// Randomised scoreboard bench for pixel_write_sched with a transaction-level model
// of pixel packing, address wrap, timeout and the clear engine.
module tb_pixel_write_sched;

  localparam int          PIX     = 4;
  localparam int          AW      = 2;
  localparam int          TMO     = 16;
  localparam logic [23:0] CCOL    = 24'h0000FF;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          clear_req;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          busy;
  logic          frame_done;
  logic          sync_err;
  logic          byte_drop;

  pixel_write_sched #(
    .PIXEL_COUNT(PIX), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO), .CLEAR_COLOR(CCOL)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .clear_req(clear_req), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .sync_err(sync_err), .byte_drop(byte_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          addr;
    logic [23:0] data;
    bit          fd;
    bit          bsy;
  } wr_exp_t;

  wr_exp_t wq[$];
  int      sq[$];
  int      dq[$];
  int      cyc   = 0;
  int      tests = 0;
  int      fails = 0;

  always @(posedge clk) cyc++;

  // Reference model state: bytes held in the current pixel, frame position, idle time.
  int         m_phase, m_addr, m_idle, m_clr_next;
  bit         m_in_clear;
  logic [7:0] m_r, m_g;

  function automatic void model_reset();
    m_phase = 0; m_addr = 0; m_idle = 0; m_clr_next = 0; m_in_clear = 0;
    m_r = '0; m_g = '0;
  endfunction

  function automatic void push_wr(int addr, logic [23:0] data, bit fd, bit bsy);
    wr_exp_t e;
    e.due = cyc + 1; e.addr = addr; e.data = data; e.fd = fd; e.bsy = bsy;
    wq.push_back(e);
  endfunction

  function automatic void model(bit rx, logic [7:0] b, bit clr);
    if (m_in_clear) begin
      if (rx) dq.push_back(cyc + 1);
      if (m_clr_next < PIX) begin
        push_wr(m_clr_next, CCOL, 1'b0, 1'b1);
        m_clr_next++;
      end else begin
        m_in_clear = 0;
      end
    end else if (clr) begin
      if (rx) dq.push_back(cyc + 1);
      m_phase = 0; m_addr = 0; m_idle = 0;
      m_in_clear = 1;
      push_wr(0, CCOL, 1'b0, 1'b1);
      m_clr_next = 1;
    end else if (rx) begin
      m_idle = 0;
      if (m_phase == 0) begin
        m_r = b; m_phase = 1;
      end else if (m_phase == 1) begin
        m_g = b; m_phase = 2;
      end else begin
        push_wr(m_addr, {m_r, m_g, b}, m_addr == PIX - 1, 1'b0);
        m_addr  = (m_addr + 1) % PIX;
        m_phase = 0;
      end
    end else if (m_phase != 0 || m_addr != 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        sq.push_back(cyc + 1);
        m_phase = 0; m_addr = 0; m_idle = 0;
      end
    end else begin
      m_idle = 0;
    end
  endfunction

  // Monitor: outputs are sampled on the falling edge, well away from the active edge.
  wr_exp_t e;
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        tests++;
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL write: unexpected wr_en at cycle %0d addr=%0d data=%h", cyc, wr_addr, wr_data);
        end else begin
          e = wq.pop_front();
          if (e.due != cyc || int'(wr_addr) != e.addr || wr_data !== e.data ||
              frame_done !== e.fd || busy !== e.bsy) begin
            fails++;
            $display("FAIL write: cycle %0d addr=%0d data=%h fd=%b busy=%b, expected cycle %0d addr=%0d data=%h fd=%b busy=%b",
                     cyc, wr_addr, wr_data, frame_done, busy, e.due, e.addr, e.data, e.fd, e.bsy);
          end
        end
      end else begin
        if (wq.size() > 0 && wq[0].due <= cyc) begin
          tests++; fails++;
          e = wq.pop_front();
          $display("FAIL write: missing at cycle %0d, expected addr=%0d data=%h", cyc, e.addr, e.data);
        end
        tests++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
          fails++;
          $display("FAIL idle_flags: cycle %0d busy=%b frame_done=%b, expected 0 0", cyc, busy, frame_done);
        end
      end

      if (sync_err) begin
        tests++;
        if (sq.size() == 0 || sq[0] != cyc) begin
          fails++;
          $display("FAIL sync_err: pulse at cycle %0d, expected %0d", cyc, (sq.size() > 0) ? sq[0] : -1);
        end
        if (sq.size() > 0) void'(sq.pop_front());
      end else if (sq.size() > 0 && sq[0] <= cyc) begin
        tests++; fails++;
        $display("FAIL sync_err: 0 at cycle %0d, expected pulse", cyc);
        void'(sq.pop_front());
      end

      if (byte_drop) begin
        tests++;
        if (dq.size() == 0 || dq[0] != cyc) begin
          fails++;
          $display("FAIL byte_drop: pulse at cycle %0d, expected %0d", cyc, (dq.size() > 0) ? dq[0] : -1);
        end
        if (dq.size() > 0) void'(dq.pop_front());
      end else if (dq.size() > 0 && dq[0] <= cyc) begin
        tests++; fails++;
        $display("FAIL byte_drop: 0 at cycle %0d, expected pulse", cyc);
        void'(dq.pop_front());
      end
    end
  end

  task automatic step(input bit rx, input logic [7:0] b, input bit clr);
    rx_ready = rx; rx_data = b; clear_req = clr;
    model(rx, b, clr);
    @(posedge clk); #1;
    rx_ready = 1'b0; clear_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    step(1'b1, r, 1'b0);
    step(1'b1, g, 1'b0);
    step(1'b1, b, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    tests++;
    if ({wr_en, wr_addr, wr_data, busy, frame_done, sync_err, byte_drop} !== '0) begin
      fails++;
      $display("FAIL %s: outputs wr_en=%b addr=%0d data=%h busy=%b fd=%b se=%b bd=%b, expected all 0",
               tag, wr_en, wr_addr, wr_data, busy, frame_done, sync_err, byte_drop);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check_outputs_zero(tag);
    wq.delete(); sq.delete(); dq.delete();
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_ready = 1'b0; rx_data = '0; clear_req = 1'b0;
    model_reset();
    #13;
    check_outputs_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;

    // Single pixel, then the partial frame times out.
    send_px(8'h11, 8'h22, 8'h33);
    idle(20);
    // Full frame with wrap and one more pixel at address 0.
    for (int i = 0; i < 5; i++) send_px(8'(i * 3), 8'(i * 3 + 1), 8'(i * 3 + 2));
    idle(20);
    // Partial pixel abandoned, then realigned.
    step(1'b1, 8'hAA, 1'b0); step(1'b1, 8'hBB, 1'b0);
    idle(TMO + 2);
    send_px(8'h01, 8'h02, 8'h03);
    // Clear with a byte arriving mid-clear and a redundant clear request.
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    idle(3);
    // Clear coincident with the B byte.
    step(1'b1, 8'h10, 1'b0); step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h30, 1'b1);
    idle(6);
    // Reset in GOT_G, and again mid-clear.
    step(1'b1, 8'h44, 1'b0); step(1'b1, 8'h45, 1'b0);
    do_reset("reset_got_g");
    step(1'b0, 8'h00, 1'b1);
    idle(2);
    do_reset("reset_mid_clear");
    send_px(8'hC1, 8'hC2, 8'hC3);
    // Random traffic with occasional stalls and clears.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r >= 97) idle(int'($urandom_range(TMO - 2, TMO + 4)));
      else step($urandom_range(0, 99) < 45, 8'($urandom), r < 3);
    end
    idle(30);
    @(negedge clk); #1;

    tests++;
    if (wq.size() != 0) begin fails++; $display("FAIL drain_writes: %0d pending, expected 0", wq.size()); end
    tests++;
    if (sq.size() != 0) begin fails++; $display("FAIL drain_sync: %0d pending, expected 0", sq.size()); end
    tests++;
    if (dq.size() != 0) begin fails++; $display("FAIL drain_drop: %0d pending, expected 0", dq.size()); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
